// File: rtl/wfg_mem_arbiter.sv
// Round-robin arbiter sharing one read port of the waveform sample memory
// between NREQ requesters; one read in flight, all outputs registered.
module wfg_mem_arbiter #(
    parameter int NREQ    = 2,
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                 io_wbs_clk,
    input  logic                 io_wbs_rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*AW-1:0]   addr_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [DW-1:0]        rdata_o,
    output logic                 busy_o,
    output logic                 csb_o,
    output logic [AW-1:0]        addr_o,
    input  logic [DW-1:0]        dout_i,
    output logic [1:0]           dbg_state
);
    localparam int OW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_DONE} state_t;

    state_t          state, state_nx;
    logic [OW-1:0]   owner, owner_nx;
    logic [OW-1:0]   last_owner, last_owner_nx;
    logic [OW-1:0]   base, idx, grant;
    logic            grant_vld;
    logic [NREQ-1:0] elig;
    logic [2:0]      cnt, cnt_nx;
    logic [NREQ-1:0] ack_nx;
    logic [AW-1:0]   addr_nx;
    logic [DW-1:0]   rdata_nx;
    logic            csb_nx, busy_nx;

    assign dbg_state = state;

    // Search starts just after the most recent owner; in DONE that owner is
    // still in the owner register and its own request is masked.
    always_comb begin
        base = (state == S_DONE) ? owner : last_owner;
        elig = req_i;
        if (state == S_DONE) elig[owner] = 1'b0;
        grant     = '0;
        grant_vld = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = OW'((int'(base) + i) % NREQ);
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        last_owner_nx = last_owner;
        cnt_nx        = cnt;
        addr_nx       = addr_o;
        rdata_nx      = rdata_o;
        ack_nx        = '0;
        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    state_nx = S_ACCESS;
                    owner_nx = grant;
                    addr_nx  = addr_i[int'(grant)*AW +: AW];
                end
            end
            S_ACCESS: begin
                cnt_nx   = 3'(MEM_LAT - 1);
                state_nx = (MEM_LAT == 1) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                cnt_nx = cnt - 3'd1;
                if (cnt == 3'd1) state_nx = S_DONE;
            end
            S_DONE: begin
                last_owner_nx = owner;
                if (grant_vld) begin
                    state_nx = S_ACCESS;
                    owner_nx = grant;
                    addr_nx  = addr_i[int'(grant)*AW +: AW];
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        // A requester that withdrew before completion gets neither ack nor data.
        if (state_nx == S_DONE && req_i[owner]) begin
            ack_nx[owner] = 1'b1;
            rdata_nx      = dout_i;
        end
        csb_nx  = (state_nx != S_ACCESS);
        busy_nx = (state_nx != S_IDLE);
    end

    always_ff @(posedge io_wbs_clk or posedge io_wbs_rst) begin
        if (io_wbs_rst) begin
            state      <= S_IDLE;
            owner      <= '0;
            last_owner <= OW'(NREQ - 1);
            cnt        <= '0;
            addr_o     <= '0;
            rdata_o    <= '0;
            ack_o      <= '0;
            csb_o      <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            cnt        <= cnt_nx;
            addr_o     <= addr_nx;
            rdata_o    <= rdata_nx;
            ack_o      <= ack_nx;
            csb_o      <= csb_nx;
            busy_o     <= busy_nx;
        end
    end
endmodule

// File: tb/tb_wfg_mem_arbiter.sv
// Bench for wfg_mem_arbiter: directed cases plus randomized two-requester traffic
// against a round-robin reference model, on a MEM_LAT=1 and a MEM_LAT=3 instance.
`timescale 1ns/1ps
module tb_wfg_mem_arbiter;
    localparam int NREQ = 2;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int W    = NREQ + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [NREQ-1:0]    req_a, ack_a, req_b, ack_b;
    logic [NREQ*AW-1:0] addr_a, addr_b;
    logic [DW-1:0]      rdata_a, dout_a, rdata_b, dout_b;
    logic               busy_a, csb_a, busy_b, csb_b;
    logic [AW-1:0]      mao_a, mao_b;
    logic [1:0]         st_a, st_b;

    wfg_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(1)) dut_a (
        .io_wbs_clk(clk), .io_wbs_rst(rst), .req_i(req_a), .addr_i(addr_a),
        .ack_o(ack_a), .rdata_o(rdata_a), .busy_o(busy_a), .csb_o(csb_a),
        .addr_o(mao_a), .dout_i(dout_a), .dbg_state(st_a));

    wfg_mem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MEM_LAT(3)) dut_b (
        .io_wbs_clk(clk), .io_wbs_rst(rst), .req_i(req_b), .addr_i(addr_b),
        .ack_o(ack_b), .rdata_o(rdata_b), .busy_o(busy_b), .csb_o(csb_b),
        .addr_o(mao_b), .dout_i(dout_b), .dbg_state(st_b));

    logic [DW-1:0] mem [0:(1<<AW)-1];
    int n_checks = 0;
    int n_pass   = 0;
    logic [W-1:0]  exp_q[$];
    logic [DW-1:0] last_exp_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Memory models: data is valid only in the last cycle of the latency
    // window (the one ending with the capturing posedge); garbage otherwise.
    int rc_a = 0, rc_b = 0;
    logic [AW-1:0] ra_a = '0, ra_b = '0;
    always @(negedge clk) begin
        if (csb_a == 1'b0) begin ra_a = mao_a; rc_a = 1; end
        else if (rc_a > 0) rc_a--;
        dout_a = (rc_a == 1) ? mem[ra_a] : $urandom;
        if (csb_b == 1'b0) begin ra_b = mao_b; rc_b = 3; end
        else if (rc_b > 0) rc_b--;
        dout_b = (rc_b == 1) ? mem[ra_b] : $urandom;
    end

    // Scoreboard monitor for instance A.
    logic prev_csb_a = 1'b1;
    logic [W-1:0] mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            if (!csb_a) check("csb_not_back_to_back", prev_csb_a, 1);
            if (ack_a != '0) begin
                check("ack_onehot", $countones(ack_a), 1);
                if (exp_q.size() == 0) check("ack_unexpected", ack_a, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    check("ack_owner", ack_a, mon_e[W-1:DW]);
                    check("ack_rdata", rdata_a, mon_e[DW-1:0]);
                    last_exp_data = mon_e[DW-1:0];
                end
            end
        end
        prev_csb_a = csb_a;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_a = '0; req_b = '0; addr_a = '0; addr_b = '0;
        repeat (2) @(negedge clk);
        check("rst_csb", {csb_b, csb_a}, 2'b11);
        check("rst_addr", {mao_b, mao_a}, '0);
        check("rst_ack", {ack_b, ack_a}, '0);
        check("rst_rdata", {rdata_b, rdata_a}, '0);
        check("rst_busy", {busy_b, busy_a}, 2'b00);
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] entry(input int k, input logic [AW-1:0] a);
        return {NREQ'(1 << k), mem[a]};
    endfunction

    logic [NREQ-1:0]    snap_req, snap_ack;
    logic [NREQ*AW-1:0] snap_addr;
    logic [AW-1:0]      ta;
    int model_last, w, kk, issued, acks, lows, last_c;
    int wt[NREQ];
    bit draining;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[10'h005] = 32'hDEADBEEF;
        rst = 1'b1; req_a = '0; req_b = '0; addr_a = '0; addr_b = '0;

        // Single request: csb low in cycle 1, ack in cycle 2
        do_reset();
        req_a = 2'b01; addr_a[0 +: AW] = 10'h005;
        exp_q.push_back({2'b01, 32'hDEADBEEF});
        step(); check("t1_csb", csb_a, 0); check("t1_addr", mao_a, 10'h005); check("t1_busy", busy_a, 1);
        step(); check("t1_ack", ack_a, 2'b01); check("t1_rdata", rdata_a, 32'hDEADBEEF);
        req_a = 2'b00;
        step(); check("t1_idle", busy_a, 0); check("t1_rdata_held", rdata_a, 32'hDEADBEEF);

        // Simultaneous requests: 0 first, then 1
        do_reset();
        req_a = 2'b11; addr_a = {10'h020, 10'h010};
        exp_q.push_back(entry(0, 10'h010)); exp_q.push_back(entry(1, 10'h020));
        step(); check("t2_addr0", mao_a, 10'h010);
        step(); check("t2_ack0", ack_a, 2'b01); req_a = 2'b10;
        step(); check("t2_csb1", csb_a, 0); check("t2_addr1", mao_a, 10'h020);
        step(); check("t2_ack1", ack_a, 2'b10); req_a = 2'b00;
        step(); check("t2_idle", busy_a, 0);

        // Both held continuously for 8 reads: strict alternation
        do_reset();
        req_a = 2'b11;
        addr_a = {10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))};
        exp_q.push_back(entry(0, addr_a[0 +: AW])); exp_q.push_back(entry(1, addr_a[AW +: AW]));
        issued = 2; acks = 0; lows = 0; last_c = -1;
        for (int c = 0; c < 40 && acks < 8; c++) begin
            step();
            if (!csb_a) lows++;
            for (int k = 0; k < NREQ; k++) begin
                if (ack_a[k]) begin
                    acks++; last_c = c;
                    if (issued < 8) begin
                        ta = 10'($urandom_range(0, 1023));
                        addr_a[k*AW +: AW] = ta;
                        exp_q.push_back(entry(k, ta));
                        issued++;
                    end else req_a[k] = 1'b0;
                end
            end
        end
        check("t3_acks", acks, 8); check("t3_csb_lows", lows, 8); check("t3_last_ack_cycle", last_c, 15);

        // Requester withdraws during ACCESS: no ack, data held
        step(); check("t4_idle_before", busy_a, 0);
        req_a = 2'b01; addr_a[0 +: AW] = 10'($urandom_range(0, 1023));
        step(); check("t4_csb", csb_a, 0); req_a = 2'b00;
        step(); check("t4_no_ack", ack_a, 0); check("t4_rdata_kept", rdata_a, last_exp_data); check("t4_done_busy", busy_a, 1);
        step(); check("t4_back_idle", busy_a, 0);
        req_a = 2'b10; addr_a[AW +: AW] = 10'h2A5;
        exp_q.push_back(entry(1, 10'h2A5));
        step(); check("t4_csb1", csb_a, 0); check("t4_addr1", mao_a, 10'h2A5);
        step(); check("t4_ack1", ack_a, 2'b10); req_a = 2'b00;
        step();

        // Asynchronous reset during ACCESS
        do_reset();
        req_a = 2'b01; addr_a[0 +: AW] = 10'h133;
        step(); check("t5_access", csb_a, 0);
        #1 rst = 1'b1;
        #1 check("t5_async_csb", csb_a, 1); check("t5_async_ack", ack_a, 0); check("t5_async_busy", busy_a, 0);
        @(negedge clk); rst = 1'b0;
        exp_q.push_back(entry(0, 10'h133));
        step(); check("t5_restart_csb", csb_a, 0); check("t5_restart_addr", mao_a, 10'h133);
        step(); check("t5_restart_ack", ack_a, 2'b01); req_a = 2'b00;
        step(); check("t5_queue_empty", exp_q.size(), 0);

        // MEM_LAT=3 instance: address sampled at grant only
        req_b = 2'b01; addr_b[0 +: AW] = 10'h3FF;
        step(); check("t6_csb", csb_b, 0); check("t6_addr", mao_b, 10'h3FF); check("t6_busy_access", busy_b, 1);
        addr_b[0 +: AW] = 10'h000;
        step(); check("t6_w1", {csb_b, busy_b, ack_b}, 4'b1100); check("t6_addr_held", mao_b, 10'h3FF);
        step(); check("t6_w2", {csb_b, busy_b, ack_b}, 4'b1100);
        step(); check("t6_ack", ack_b, 2'b01); check("t6_rdata", rdata_b, mem[10'h3FF]); check("t6_busy_done", busy_b, 1);
        req_b = 2'b00;
        step(); check("t6_idle", busy_b, 0);

        // Randomized traffic on instance A against a round-robin model
        do_reset();
        model_last = NREQ - 1; snap_req = '0; snap_ack = '0; snap_addr = '0; draining = 1'b0;
        for (int k = 0; k < NREQ; k++) wt[k] = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            step();
            if (!csb_a) begin
                // Winner: first requester after the previous winner that was asking
                // in the arbitration cycle, excluding one that was just served then.
                w = -1;
                for (int j = 1; j <= NREQ; j++) begin
                    kk = (model_last + j) % NREQ;
                    if (w < 0 && snap_req[kk] && !snap_ack[kk]) w = kk;
                end
                if (w < 0) check("grant_without_request", csb_a, 1);
                else begin
                    ta = snap_addr[w*AW +: AW];
                    check("grant_addr", mao_a, ta);
                    exp_q.push_back(entry(w, ta));
                    model_last = w;
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                if (req_a[k]) begin
                    if (ack_a[k]) begin
                        wt[k] = 0;
                        if (!draining && $urandom_range(0, 1) == 1)
                            addr_a[k*AW +: AW] = 10'($urandom_range(0, 1023));
                        else req_a[k] = 1'b0;
                    end else begin
                        wt[k]++;
                        if (wt[k] == 12) check("req_wait_cycles", wt[k], 11);
                    end
                end else if (!draining && $urandom_range(0, 2) == 0) begin
                    req_a[k] = 1'b1;
                    addr_a[k*AW +: AW] = 10'($urandom_range(0, 1023));
                    wt[k] = 0;
                end
            end
            snap_req = req_a; snap_addr = addr_a; snap_ack = ack_a;
            if (cyc >= 600) draining = 1'b1;
            if (draining && req_a == '0 && !busy_a) break;
        end
        repeat (3) step();
        check("rand_drained_req", req_a, 0);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_idle", busy_a, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
